// File: rtl/clock_ctrl_pkg.sv
// Shared types, rate indices and period lookup for the CPU clock-enable sequencer.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam logic [1:0] RATE_0 = 2'd0;
  localparam logic [1:0] RATE_1 = 2'd1;
  localparam logic [1:0] RATE_2 = 2'd2;
  localparam logic [1:0] RATE_3 = 2'd3;

  // Periods below 2 would make the divider terminal on every cycle; clamp them.
  function automatic logic [31:0] period_of(input logic [1:0]  sel,
                                            input logic [31:0] p0,
                                            input logic [31:0] p1,
                                            input logic [31:0] p2,
                                            input logic [31:0] p3);
    logic [31:0] p;
    case (sel)
      RATE_0:  p = p0;
      RATE_1:  p = p1;
      RATE_2:  p = p2;
      default: p = p3;
    endcase
    if (p < 32'd2) p = 32'd2;
    return p;
  endfunction

endpackage

// File: rtl/clock_controller_rate_divider.sv
// Free-running divider: counts up while enabled, wraps at period-1 and flags it.
module rate_divider #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  // >= rather than == so a switch to a shorter period terminates immediately.
  assign terminal = (count >= (period - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || terminal) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_controller.sv
// CPU clock-enable sequencer: stopped/single-step, free-run at four rates, HLT and resume.
module clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int               CNT_W = 24,
  parameter logic [CNT_W-1:0] DIV0  = 24'd12_000_000,
  parameter logic [CNT_W-1:0] DIV1  = 24'd1_200_000,
  parameter logic [CNT_W-1:0] DIV2  = 24'd120_000,
  parameter logic [CNT_W-1:0] DIV3  = 24'd1_200,
  parameter int               CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_mode,
  input  logic             step_pulse,
  input  logic             resume_pulse,
  input  logic             hlt,
  input  logic [1:0]       rate_sel,
  output logic             cpu_clk_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CYC_W-1:0] cycle_count
);

  // step_pulse and resume_pulse are single-cycle requests sampled on every
  // clk edge; there is no ready/back-pressure, a pulse that the current
  // state ignores is simply dropped. cpu_clk_en is a one-cycle strobe.

  state_t           state_q;
  state_t           state_d;
  logic             fire;
  logic             div_clear;
  logic             div_terminal;
  logic [CNT_W-1:0] period;

  assign period = CNT_W'(period_of(rate_sel, 32'(DIV0), 32'(DIV1),
                                   32'(DIV2), 32'(DIV3)));

  rate_divider #(
    .CNT_W(CNT_W)
  ) u_rate_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (div_clear),
    .period  (period),
    .terminal(div_terminal)
  );

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      STOPPED: begin
        if (run_mode) begin
          state_d = RUN;
        end else if (step_pulse) begin
          if (hlt) state_d = HALTED;
          else     fire    = 1'b1;
        end
      end
      RUN: begin
        if (!run_mode) begin
          state_d = STOPPED;
        end else if (div_terminal) begin
          if (hlt) state_d = HALTED;
          else     fire    = 1'b1;
        end
      end
      HALTED: begin
        // Resume always strobes so the CPU steps past its HLT microstep.
        if (resume_pulse) begin
          fire    = 1'b1;
          state_d = run_mode ? RUN : STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  // The divider only keeps counting while RUN persists; any entry or exit restarts it at 0.
  assign div_clear = !((state_q == RUN) && (state_d == RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STOPPED;
      cpu_clk_en  <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q    <= state_d;
      cpu_clk_en <= fire;
      halted     <= (state_d == HALTED);
      if (cpu_clk_en) cycle_count <= cycle_count + CYC_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller: step, run rates, rate change, halt/resume, wrap, async reset.
module tb_clock_controller;

  logic        clk;
  logic        rst_n;
  logic        run_mode, step_pulse, resume_pulse, hlt;
  logic [1:0]  rate_sel;
  logic        cpu_clk_en, halted;
  logic [1:0]  state;
  logic [15:0] cycle_count;

  logic        w_run_mode;
  logic [1:0]  w_rate_sel;
  logic        w_cpu_clk_en, w_halted;
  logic [1:0]  w_state;
  logic [7:0]  w_cycle_count;

  int vectors;
  int miscompares;

  clock_controller #(
    .DIV2(24'd20),
    .DIV3(24'd5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_mode    (run_mode),
    .step_pulse  (step_pulse),
    .resume_pulse(resume_pulse),
    .hlt         (hlt),
    .rate_sel    (rate_sel),
    .cpu_clk_en  (cpu_clk_en),
    .halted      (halted),
    .state       (state),
    .cycle_count (cycle_count)
  );

  // Narrow counter with the fastest legal rate so the wrap is reachable quickly.
  clock_controller #(
    .DIV3 (24'd2),
    .CYC_W(8)
  ) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_mode    (w_run_mode),
    .step_pulse  (1'b0),
    .resume_pulse(1'b0),
    .hlt         (1'b0),
    .rate_sel    (w_rate_sel),
    .cpu_clk_en  (w_cpu_clk_en),
    .halted      (w_halted),
    .state       (w_state),
    .cycle_count (w_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b exp 0", cpu_clk_en); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b exp 0", halted); end
    vectors++;
    if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
    vectors++;
    if (w_cycle_count !== 8'd0) begin miscompares++; $display("FAIL reset_w_count got %0d exp 0", w_cycle_count); end
    rst_n = 1'b1;
    for (int i = 3; i < 10; i++) begin
      tick();
      vectors++;
      if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL idle_en cyc %0d got %b exp 0", i, cpu_clk_en); end
    end
  endtask

  task automatic test_step();
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    vectors++;
    if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL step_en got %b exp 1", cpu_clk_en); end
    tick();
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL step_en_off got %b exp 0", cpu_clk_en); end
    vectors++;
    if (cycle_count !== 16'd1) begin miscompares++; $display("FAIL step_count got %0d exp 1", cycle_count); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL step_state got %0d exp 0", state); end
  endtask

  task automatic test_back_to_back();
    step_pulse = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL b2b_en k=%0d got %b exp 1", k, cpu_clk_en); end
    end
    step_pulse = 1'b0;
    tick();
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL b2b_en_off got %b exp 0", cpu_clk_en); end
    vectors++;
    if (cycle_count !== 16'd4) begin miscompares++; $display("FAIL b2b_count got %0d exp 4", cycle_count); end
  endtask

  task automatic test_run_rate();
    logic exp_en;
    rate_sel = 2'd3;
    run_mode = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      tick();
      exp_en = (k >= 6) && (((k - 6) % 5) == 0);
      vectors++;
      if (cpu_clk_en !== exp_en) begin miscompares++; $display("FAIL run_en tick %0d got %b exp %b", k, cpu_clk_en, exp_en); end
    end
    tick();
    vectors++;
    if (cycle_count !== 16'd14) begin miscompares++; $display("FAIL run_count got %0d exp 14", cycle_count); end
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL run_state got %0d exp 1", state); end
    run_mode = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      vectors++;
      if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL stop_en tick %0d got %b exp 0", k, cpu_clk_en); end
    end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL stop_state got %0d exp 0", state); end
    vectors++;
    if (cycle_count !== 16'd14) begin miscompares++; $display("FAIL stop_count got %0d exp 14", cycle_count); end
  endtask

  task automatic test_rate_change();
    logic exp_en;
    rate_sel = 2'd2;
    run_mode = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 13) rate_sel = 2'd3;
      exp_en = (k == 14) || (k == 19) || (k == 24);
      vectors++;
      if (cpu_clk_en !== exp_en) begin miscompares++; $display("FAIL rchg_en tick %0d got %b exp %b", k, cpu_clk_en, exp_en); end
    end
    run_mode = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL rchg_state got %0d exp 0", state); end
    vectors++;
    if (cycle_count !== 16'd17) begin miscompares++; $display("FAIL rchg_count got %0d exp 17", cycle_count); end
  endtask

  task automatic test_halt_run();
    rate_sel = 2'd3;
    hlt = 1'b0;
    run_mode = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 7) hlt = 1'b1;
      vectors++;
      if (cpu_clk_en !== (k == 6)) begin miscompares++; $display("FAIL hrun_en tick %0d got %b exp %b", k, cpu_clk_en, (k == 6)); end
    end
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL hrun_state got %0d exp 2", state); end
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL hrun_halted got %b exp 1", halted); end
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    tick();
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL hstep_en got %b exp 0", cpu_clk_en); end
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL hstep_state got %0d exp 2", state); end
    resume_pulse = 1'b1;
    tick();
    resume_pulse = 1'b0;
    vectors++;
    if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL resume_en got %b exp 1", cpu_clk_en); end
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL resume_state got %0d exp 1", state); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("FAIL resume_halted got %b exp 0", halted); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL rehalt_en tick %0d got %b exp 0", k, cpu_clk_en); end
    end
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL rehalt_state got %0d exp 2", state); end
    run_mode = 1'b0;
    tick();
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL hmode_state got %0d exp 2", state); end
    resume_pulse = 1'b1;
    tick();
    resume_pulse = 1'b0;
    vectors++;
    if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL resume2_en got %b exp 1", cpu_clk_en); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL resume2_state got %0d exp 0", state); end
    hlt = 1'b0;
    tick();
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL resume2_off got %b exp 0", cpu_clk_en); end
    vectors++;
    if (cycle_count !== 16'd20) begin miscompares++; $display("FAIL hrun_count got %0d exp 20", cycle_count); end
  endtask

  task automatic test_step_halt();
    run_mode = 1'b0;
    hlt = 1'b1;
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL shalt_en got %b exp 0", cpu_clk_en); end
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL shalt_state got %0d exp 2", state); end
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL shalt_halted got %b exp 1", halted); end
    resume_pulse = 1'b1;
    tick();
    resume_pulse = 1'b0;
    vectors++;
    if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL sresume_en got %b exp 1", cpu_clk_en); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL sresume_state got %0d exp 0", state); end
    hlt = 1'b0;
    tick();
    vectors++;
    if (cycle_count !== 16'd21) begin miscompares++; $display("FAIL shalt_count got %0d exp 21", cycle_count); end
  endtask

  task automatic test_wrap();
    w_rate_sel = 2'd3;
    w_run_mode = 1'b1;
    for (int k = 0; k < 512; k++) tick();
    vectors++;
    if (w_cycle_count !== 8'hFF) begin miscompares++; $display("FAIL wrap_pre got %0h exp ff", w_cycle_count); end
    tick();
    vectors++;
    if (w_cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL wrap_en got %b exp 1", w_cpu_clk_en); end
    tick();
    vectors++;
    if (w_cycle_count !== 8'h00) begin miscompares++; $display("FAIL wrap_post got %0h exp 0", w_cycle_count); end
  endtask

  task automatic test_async_reset();
    rate_sel = 2'd3;
    run_mode = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    vectors++;
    if (cpu_clk_en !== 1'b1) begin miscompares++; $display("FAIL arst_pre_en got %b exp 1", cpu_clk_en); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL arst_en got %b exp 0", cpu_clk_en); end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL arst_state got %0d exp 0", state); end
    vectors++;
    if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL arst_count got %0d exp 0", cycle_count); end
    vectors++;
    if (w_state !== 2'd0) begin miscompares++; $display("FAIL arst_w_state got %0d exp 0", w_state); end
    vectors++;
    if (w_halted !== 1'b0) begin miscompares++; $display("FAIL arst_w_halted got %b exp 0", w_halted); end
    run_mode = 1'b0;
    w_run_mode = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      vectors++;
      if (cpu_clk_en !== 1'b0) begin miscompares++; $display("FAIL post_rst_en tick %0d got %b exp 0", k, cpu_clk_en); end
    end
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL post_rst_state got %0d exp 0", state); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    run_mode     = 1'b0;
    step_pulse   = 1'b0;
    resume_pulse = 1'b0;
    hlt          = 1'b0;
    rate_sel     = 2'd0;
    w_run_mode   = 1'b0;
    w_rate_sel   = 2'd0;
    test_reset();
    test_step();
    test_back_to_back();
    test_run_rate();
    test_rate_change();
    test_halt_run();
    test_step_halt();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
